// File: rtl/serv_lsu_w.sv
// W-bit-serial load/store unit: shifts store data in, runs a Wishbone data
// cycle, aligns/extends load data and shifts it back out W bits per cycle.
module serv_lsu_w #(
    parameter int unsigned W        = 1,
    parameter bit          WITH_CSR = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_we,
    input  logic         i_word,
    input  logic         i_half,
    input  logic         i_signed,
    input  logic [1:0]   i_lsb,
    input  logic [W-1:0] i_op_b,
    output logic [W-1:0] o_rd,
    output logic         o_rd_valid,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_misalign,
    output logic         o_wb_cyc,
    output logic         o_wb_we,
    output logic [3:0]   o_wb_sel,
    output logic [31:0]  o_wb_dat,
    input  logic [31:0]  i_wb_rdt,
    input  logic         i_wb_ack
);

    localparam int unsigned N  = 32 / W;
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TRAP  = 3'd1,
        SHIN  = 3'd2,
        BUS   = 3'd3,
        SHOUT = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   dat, dat_nxt;
    logic          we_q, word_q, half_q, signed_q;
    logic [1:0]    lsb_q;
    logic          store_done, store_done_nxt;

    logic          last;
    logic          start_ok;
    logic          misalign_c;
    logic [7:0]    lane8;
    logic [15:0]   lane16;
    logic [31:0]   rdt_ext;
    logic [3:0]    sel;
    logic [31:0]   wdat;

    assign last       = (cnt == CW'(N - 1));
    // The store-done cycle is already IDLE; a start there is not taken.
    assign start_ok   = i_start && !store_done;
    assign misalign_c = WITH_CSR && ((i_lsb[0] && (i_word || i_half)) ||
                                     (i_lsb[1] && i_word));

    // Load lane selection and extension.
    always_comb begin
        lane8  = 8'(i_wb_rdt >> {lsb_q, 3'b000});
        lane16 = 16'(i_wb_rdt >> {lsb_q[1], 4'b0000});
        if (word_q)
            rdt_ext = i_wb_rdt;
        else if (half_q)
            rdt_ext = {{16{signed_q & lane16[15]}}, lane16};
        else
            rdt_ext = {{24{signed_q & lane8[7]}}, lane8};
    end

    // Store lane enables and replicated write data.
    always_comb begin
        if (word_q) begin
            sel  = 4'b1111;
            wdat = dat;
        end else if (half_q) begin
            sel  = lsb_q[1] ? 4'b1100 : 4'b0011;
            wdat = {2{dat[15:0]}};
        end else begin
            sel  = 4'b0001 << lsb_q;
            wdat = {4{dat[7:0]}};
        end
    end

    // Next-state, counter and data path.
    always_comb begin
        state_nxt      = state;
        dat_nxt        = dat;
        store_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (misalign_c)
                        state_nxt = TRAP;
                    else if (i_we)
                        state_nxt = SHIN;
                    else
                        state_nxt = BUS;
                end
            end
            TRAP: state_nxt = IDLE;
            SHIN: begin
                dat_nxt = {i_op_b, dat[31:W]};
                if (last)
                    state_nxt = BUS;
            end
            BUS: begin
                if (i_wb_ack) begin
                    if (we_q) begin
                        state_nxt      = IDLE;
                        store_done_nxt = 1'b1;
                    end else begin
                        state_nxt = SHOUT;
                        dat_nxt   = rdt_ext;
                    end
                end
            end
            SHOUT: begin
                dat_nxt = dat >> W;
                if (last)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if (state_nxt != state)
            cnt_nxt = '0;
        else if (state == SHIN || state == SHOUT)
            cnt_nxt = cnt + 1'b1;
        else
            cnt_nxt = cnt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dat        <= '0;
            we_q       <= 1'b0;
            word_q     <= 1'b0;
            half_q     <= 1'b0;
            signed_q   <= 1'b0;
            lsb_q      <= 2'b00;
            store_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dat        <= dat_nxt;
            store_done <= store_done_nxt;
            if (state == IDLE && start_ok) begin
                we_q     <= i_we;
                word_q   <= i_word;
                half_q   <= i_half;
                signed_q <= i_signed;
                lsb_q    <= i_lsb;
            end
        end
    end

    // Outputs decode the registered state only; nothing flows from ack to cyc.
    assign o_busy     = (state != IDLE);
    assign o_wb_cyc   = (state == BUS);
    assign o_wb_we    = o_wb_cyc & we_q;
    assign o_wb_sel   = o_wb_cyc ? sel  : 4'b0000;
    assign o_wb_dat   = o_wb_cyc ? wdat : 32'h0;
    assign o_rd_valid = (state == SHOUT);
    assign o_rd       = o_rd_valid ? dat[W-1:0] : '0;
    assign o_done     = store_done | (o_rd_valid & last);
    assign o_misalign = (state == TRAP);

endmodule
